// File: rtl/host_queue_arbiter.sv
// rtl/host_queue_arbiter.sv - N-channel descriptor FIFOs with round-robin/strict arbiter
// Optional HQA_DISCARD_CNT_EN adds ov_discard_cnt, one saturating 16-bit drop counter per channel.
module host_queue_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int BUFID_W    = 9
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_CH*48-1:0]        iv_tsntag,
    input  logic [NUM_CH*BUFID_W-1:0]   iv_bufid,
    input  logic [NUM_CH-1:0]           iv_inverse_map_lookup_flag,
    input  logic [NUM_CH-1:0]           i_descriptor_wr,
    output logic [NUM_CH-1:0]           o_descriptor_ack,
    input  logic                        i_arb_mode,
    output logic [49+BUFID_W-1:0]       ov_descriptor,
    output logic                        o_descriptor_wr,
    input  logic                        i_descriptor_ready,
    output logic [NUM_CH-1:0]           o_inqueue_discard_pulse,
    output logic [1:0]                  ov_hqa_state
`ifdef HQA_DISCARD_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]        ov_discard_cnt
`endif
);

    localparam int DESC_W = 49 + BUFID_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   nonempty, full_vec, pop;
    logic [DESC_W-1:0]   head [NUM_CH];
    logic [CH_W-1:0]     grant, rr_q, rr_d;
    logic                grant_vld;
    logic [DESC_W-1:0]   desc_q, desc_d;
    logic                desc_wr_q, desc_wr_d;
    logic [NUM_CH-1:0]   ack_q, discard_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DESC_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              push;

        // Fullness is judged on the registered count, so a same-cycle pop never rescues a write.
        assign full_vec[k] = (cnt_q == CNT_W'(FIFO_DEPTH));
        assign push        = i_descriptor_wr[k] & ~full_vec[k];
        assign nonempty[k] = (cnt_q != '0);
        assign head[k]     = mem_q[rd_ptr_q];

        always_ff @(posedge i_clk) begin
            if (push)
                mem_q[wr_ptr_q] <= {iv_inverse_map_lookup_flag[k], iv_tsntag[k*48 +: 48],
                                    iv_bufid[k*BUFID_W +: BUFID_W]};
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop[k]) rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop[k]})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

`ifdef HQA_DISCARD_CNT_EN
        logic [15:0] dcnt_q;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                dcnt_q <= '0;
            else if (discard_q[k] && dcnt_q != 16'hFFFF)
                dcnt_q <= dcnt_q + 16'd1;
        end
        assign ov_discard_cnt[k*16 +: 16] = dcnt_q;
`endif
    end

    // Strict mode scans from channel 0; round-robin scans upward from rr_q with wrap.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            int idx;
            idx = i_arb_mode ? i : int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld && nonempty[CH_W'(idx)]) begin
                grant_vld = 1'b1;
                grant     = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_descriptor_ready && grant_vld) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = '0;
        desc_d    = desc_q;
        desc_wr_d = 1'b0;
        rr_d      = rr_q;
        if (state_q == IDLE && i_descriptor_ready && grant_vld) begin
            pop[grant] = 1'b1;
            desc_d     = head[grant];
            desc_wr_d  = 1'b1;
            if (!i_arb_mode)
                rr_d = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            desc_q    <= '0;
            desc_wr_q <= 1'b0;
            rr_q      <= '0;
            ack_q     <= '0;
            discard_q <= '0;
        end else begin
            desc_q    <= desc_d;
            desc_wr_q <= desc_wr_d;
            rr_q      <= rr_d;
            ack_q     <= i_descriptor_wr;
            discard_q <= i_descriptor_wr & full_vec;
        end
    end

    assign ov_descriptor           = desc_q;
    assign o_descriptor_wr         = desc_wr_q;
    assign o_descriptor_ack        = ack_q;
    assign o_inqueue_discard_pulse = discard_q;
    assign ov_hqa_state            = state_q;

endmodule

// File: tb/tb_host_queue_arbiter.sv
// tb/tb_host_queue_arbiter.sv - directed self-checking bench for host_queue_arbiter
module tb_host_queue_arbiter;

    localparam int NUM_CH  = 2;
    localparam int BUFID_W = 9;
    localparam int DESC_W  = 49 + BUFID_W;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_CH*48-1:0]      tsntag;
    logic [NUM_CH*BUFID_W-1:0] bufid;
    logic [NUM_CH-1:0]         flag;
    logic [NUM_CH-1:0]         wr;
    logic [NUM_CH-1:0]         ack;
    logic                      arb_mode;
    logic [DESC_W-1:0]         desc;
    logic                      desc_wr;
    logic                      ready;
    logic [NUM_CH-1:0]         discard;
    logic [1:0]                state;
`ifdef HQA_DISCARD_CNT_EN
    logic [NUM_CH*16-1:0]      discard_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [BUFID_W-1:0] out_q [$];
    int                 out_cyc [$];

    host_queue_arbiter #(.NUM_CH(NUM_CH), .FIFO_DEPTH(4), .BUFID_W(BUFID_W)) dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .iv_tsntag                  (tsntag),
        .iv_bufid                   (bufid),
        .iv_inverse_map_lookup_flag (flag),
        .i_descriptor_wr            (wr),
        .o_descriptor_ack           (ack),
        .i_arb_mode                 (arb_mode),
        .ov_descriptor              (desc),
        .o_descriptor_wr            (desc_wr),
        .i_descriptor_ready         (ready),
        .o_inqueue_discard_pulse    (discard),
        .ov_hqa_state               (state)
`ifdef HQA_DISCARD_CNT_EN
        ,
        .ov_discard_cnt             (discard_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && desc_wr) begin
            out_q.push_back(desc[BUFID_W-1:0]);
            out_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr    = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic preload3();
        for (int i = 0; i < 3; i++) begin
            bufid = {9'(9'h020 + i), 9'(9'h010 + i)};
            wr    = 2'b11;
            tick(1);
        end
        wr = '0;
        tick(1);
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic check_order(input string tag, input logic [BUFID_W-1:0] e0, e1, e2, e3, e4, e5);
        logic [BUFID_W-1:0] exp [6];
        exp = '{e0, e1, e2, e3, e4, e5};
        check({tag, "_count"}, 64'(out_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            check($sformatf("%s_item%0d", tag, i), 64'(out_q[i]), 64'(exp[i]));
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), 64'(out_cyc[i] - out_cyc[i-1]), 64'd2);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tsntag   = '0;
        bufid    = '0;
        flag     = '0;
        wr       = '0;
        arb_mode = 1'b0;
        ready    = 1'b0;
        tick(2);
        check("rst_desc_wr", 64'(desc_wr), 64'd0);
        check("rst_desc", 64'(desc), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        rst_n = 1'b1;
        ready = 1'b1;
        tick(6);
        check("idle_state", 64'(state), 64'd0);
        check("idle_strobes", 64'(out_q.size()), 64'd0);
        check("idle_discard", 64'(discard), 64'd0);

        // Single write on ch0: ack at T+1, strobe at T+2
        tsntag = {48'h0, 48'h0123_4567_89AB};
        bufid  = {9'h0, 9'h005};
        flag   = 2'b01;
        wr     = 2'b01;
        tick(1);
        wr = '0;
        check("single_ack", 64'(ack), 64'd1);
        check("single_wr_early", 64'(desc_wr), 64'd0);
        tick(1);
        check("single_wr", 64'(desc_wr), 64'd1);
        check("single_desc", 64'(desc), 64'({1'b1, 48'h0123_4567_89AB, 9'h005}));
        check("single_state_hold", 64'(state), 64'd1);
        tick(1);
        check("single_wr_end", 64'(desc_wr), 64'd0);
        check("single_ack_end", 64'(ack), 64'd0);
        check("single_state_idle", 64'(state), 64'd0);

        // Round-robin alternation
        ready = 1'b0;
        do_reset();
        arb_mode = 1'b0;
        preload3();
        ready = 1'b1;
        tick(16);
        check_order("rr", 9'h010, 9'h020, 9'h011, 9'h021, 9'h012, 9'h022);

        // Strict priority drains ch0 first
        ready = 1'b0;
        do_reset();
        arb_mode = 1'b1;
        preload3();
        ready = 1'b1;
        tick(16);
        check_order("strict", 9'h010, 9'h011, 9'h012, 9'h020, 9'h021, 9'h022);

        // Overflow on ch1 with depth 4
        ready    = 1'b0;
        arb_mode = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bufid = {9'(9'h030 + i), 9'h0};
            wr    = 2'b10;
            tick(1);
            check($sformatf("ovf_ack%0d", i), 64'(ack), 64'd2);
            check($sformatf("ovf_discard%0d", i), 64'(discard), (i >= 4) ? 64'd2 : 64'd0);
        end
        // Pop in the same cycle as a write to a full FIFO does not save the write
        bufid = {9'h03F, 9'h0};
        wr    = 2'b10;
        ready = 1'b1;
        tick(1);
        wr = '0;
        check("ovf_same_cycle_discard", 64'(discard), 64'd2);
        tick(1);
        check("ovf_ack_clear", 64'(ack), 64'd0);
`ifdef HQA_DISCARD_CNT_EN
        check("ovf_discard_cnt_ch1", 64'(discard_cnt[31:16]), 64'd3);
        check("ovf_discard_cnt_ch0", 64'(discard_cnt[15:0]), 64'd0);
`endif
        tick(12);
        check("ovf_count", 64'(out_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < out_q.size(); i++)
            check($sformatf("ovf_item%0d", i), 64'(out_q[i]), 64'(9'h030 + i));

        // Reset while ch0 holds two entries
        ready = 1'b0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bufid = {9'h0, 9'(9'h050 + i)};
            wr    = 2'b01;
            tick(1);
        end
        wr = '0;
        tick(1);
        rst_n = 1'b0;
        #2;
        check("midrst_ack", 64'(ack), 64'd0);
        tick(1);
        rst_n = 1'b1;
        ready = 1'b1;
        out_q.delete();
        tick(8);
        check("midrst_no_strobe", 64'(out_q.size()), 64'd0);
        check("midrst_state", 64'(state), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
